spi_slave_port: RTL
===================

// Module: spi_slave_port
// PURPOSE
//  SPI target end of the link driven by master_spi: shifts a byte in on MOSI and a byte out on
//  MISO per 8 SCLK cycles while SS is low. Oversamples SS/SCLK/MOSI on the local CLK, so SCLK
//  is never used as a clock. Local side: TX holding register (valid/ready) and RX holding register
//  (valid/ack) plus sticky status flags. Sits in peripheral-side FPGA logic facing the SPI pins.
// PARAMETERS
//  SYNC_STAGES  2      synchronizer depth on SS, SCLK, MOSI (>=2)
//  FILL_BYTE    8'hFF  byte shifted out when no TX byte is pending at a byte boundary
// PORTS
//  CLK        in   1  local clock; all state on posedge
//  RST        in   1  asynchronous, active-high reset
//  SS         in   1  SPI select, active low
//  SCLK       in   1  SPI clock, idles high
//  MOSI       in   1  serial data in
//  MISO       out  1  serial data out
//  MISO_OE    out  1  1 = drive MISO pad (SS low, synced)
//  TX_DATA    in   8  next byte to send
//  TX_VALID   in   1  TX_DATA offered
//  TX_READY   out  1  holding register empty; byte accepted when TX_VALID & TX_READY
//  RX_DATA    out  8  last complete received byte
//  RX_VALID   out  1  RX_DATA unread; held until RX_ACK
//  RX_ACK     in   1  consume RX_DATA (ignored while RX_VALID=0)
//  OVERRUN    out  1  sticky: byte completed while RX_VALID=1 and no RX_ACK that cycle
//  UNDERRUN   out  1  sticky: FILL_BYTE loaded because TX holding register empty
//  FRAME_ERR  out  1  sticky: SS rose with partial byte (bit count 1..7)
//  CLR_FLAGS  in   1  clears OVERRUN/UNDERRUN/FRAME_ERR; a same-cycle set wins
// BEHAVIOUR
//  Reset: MISO=1, MISO_OE=0, TX_READY=1, RX_DATA=0, RX_VALID=0, all flags 0, bitcnt=0, state LOCKOUT.
//  Timing (mode CPOL=1): master samples MISO while SCLK high, changes MOSI on SCLK rise.
//   Slave samples MOSI on synced SCLK fall; updates MISO on synced SCLK rise.
//  Edges = synced SCLK transitions detected one CLK after sync output; SCLK edges with synced SS
//   high are ignored. Each SCLK phase must last >= SYNC_STAGES+2 CLK periods.
//  FSM: LOCKOUT -> IDLE when synced SS=1 (a transfer in progress at reset is never joined).
//   IDLE -> ACTIVE on synced SS fall: load tx_sh <= holding (TX_READY->1) or FILL_BYTE
//   (set UNDERRUN); bitcnt=0; MISO_OE=1, MISO=tx_sh[7] from this cycle.
//   ACTIVE fall: rx_sh <= {rx_sh[6:0],MOSI}; bitcnt <= bitcnt+1 mod 8. On wrap to 0:
//   RX_DATA <= byte, RX_VALID=1; if RX_VALID was 1 and no RX_ACK this cycle, set OVERRUN
//   (new byte overwrites). RX_ACK coincident with completion: RX_VALID stays 1, no OVERRUN.
//   ACTIVE rise: bitcnt==0 -> reload tx_sh as at SS fall (next byte); else shift tx_sh left, fill 1.
//   ACTIVE -> IDLE on synced SS rise: MISO_OE=0, MISO=1; bitcnt!=0 -> FRAME_ERR, partial
//   rx_sh discarded, no RX_VALID. Unconsumed TX holding byte kept for next frame.
//  TX holding: 1 byte; accept only when TX_READY; TX_READY drops the cycle after accept,
//   rises the cycle after a load consumes it. Accept and load in same cycle: load takes
//   the old contents if full, else FILL_BYTE; the new byte is then held.
//  RST asserted mid-frame: immediate return to reset values; re-enter via LOCKOUT.
// TESTING
//  1 TX_DATA=8'hA5 queued, master sends 8'h3C -> MISO bits 1,0,1,0,0,1,0,1; RX_DATA=8'h3C, RX_VALID=1.
//  2 two-byte frame, TX holds 8'h11 only -> 2nd byte out 8'hFF, UNDERRUN=1; RX_VALID after each byte.
//  3 two bytes received, no RX_ACK -> RX_DATA=2nd byte, OVERRUN=1; repeat with RX_ACK on completion
//    cycle -> OVERRUN=0, RX_VALID=1.
//  4 SS raised after 5 SCLK cycles -> FRAME_ERR=1, RX_VALID unchanged, MISO_OE=0; CLR_FLAGS -> 0.
//  5 RST pulsed mid-byte with SS low -> outputs at reset values; SCLK toggling ignored until SS
//    high then low; next full byte received correctly.
//  6 SCLK toggles with SS high -> no RX_VALID, MISO_OE=0, TX holding byte not consumed.

Source files
------------

// File: rtl/spi_slave_port.sv
// ============================================================================
// spi_slave_port : oversampled SPI target (CPOL=1) with TX/RX holding registers
// Rev 1.0
// ============================================================================
`default_nettype none

module spi_slave_port #(
  parameter int          SYNC_STAGES = 2,
  parameter logic [7:0]  FILL_BYTE   = 8'hFF
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       ss_i,
  input  logic       sclk_i,
  input  logic       mosi_i,
  output logic       miso_o,
  output logic       miso_oe_o,
  input  logic [7:0] tx_data_i,
  input  logic       tx_valid_i,
  output logic       tx_ready_o,
  output logic [7:0] rx_data_o,
  output logic       rx_valid_o,
  input  logic       rx_ack_i,
  output logic       overrun_o,
  output logic       underrun_o,
  output logic       frame_err_o,
  input  logic       clr_flags_i
);

  typedef enum logic [1:0] {ST_LOCKOUT = 2'd0, ST_IDLE = 2'd1, ST_ACTIVE = 2'd2} state_e;

  logic [SYNC_STAGES-1:0] ss_sync_q, sclk_sync_q, mosi_sync_q;
  logic       ss_s, sclk_s, mosi_s;
  logic       sclk_fall, sclk_rise, load, accept, rx_done, ovr_set, udr_set, ferr_set;

  state_e     state_q, state_d;
  logic       sclk_prev_q, sclk_prev_d;
  logic [7:0] tx_sh_q, tx_sh_d;
  logic [6:0] rx_sh_q, rx_sh_d;
  logic [2:0] bitcnt_q, bitcnt_d;
  logic [7:0] hold_q, hold_d;
  logic       hold_full_q, hold_full_d;
  logic [7:0] rx_data_q, rx_data_d;
  logic       rx_valid_q, rx_valid_d;
  logic       ovr_q, ovr_d, udr_q, udr_d, ferr_q, ferr_d;

  // SS synchronizer resets to "selected" so a frame already in progress stays locked out.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ss_sync_q   <= '0;
      sclk_sync_q <= '1;
      mosi_sync_q <= '0;
    end else begin
      ss_sync_q   <= {ss_sync_q[SYNC_STAGES-2:0], ss_i};
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sclk_i};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi_i};
    end
  end

  assign ss_s      = ss_sync_q[SYNC_STAGES-1];
  assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
  assign sclk_fall = sclk_prev_q & ~sclk_s;
  assign sclk_rise = ~sclk_prev_q & sclk_s;
  assign accept    = tx_valid_i & ~hold_full_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= ST_LOCKOUT;
      sclk_prev_q <= 1'b1;
      tx_sh_q     <= 8'hFF;
      rx_sh_q     <= '0;
      bitcnt_q    <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      ovr_q       <= 1'b0;
      udr_q       <= 1'b0;
      ferr_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      sclk_prev_q <= sclk_prev_d;
      tx_sh_q     <= tx_sh_d;
      rx_sh_q     <= rx_sh_d;
      bitcnt_q    <= bitcnt_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      ovr_q       <= ovr_d;
      udr_q       <= udr_d;
      ferr_q      <= ferr_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    sclk_prev_d = sclk_s;
    tx_sh_d     = tx_sh_q;
    rx_sh_d     = rx_sh_q;
    bitcnt_d    = bitcnt_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = rx_valid_q;
    load        = 1'b0;
    rx_done     = 1'b0;
    ovr_set     = 1'b0;
    udr_set     = 1'b0;
    ferr_set    = 1'b0;

    case (state_q)
      ST_LOCKOUT: if (ss_s) state_d = ST_IDLE;
      ST_IDLE: begin
        if (!ss_s) begin
          state_d  = ST_ACTIVE;
          load     = 1'b1;
          bitcnt_d = '0;
        end
      end
      ST_ACTIVE: begin
        if (ss_s) begin
          state_d  = ST_IDLE;
          ferr_set = (bitcnt_q != 3'd0);
          bitcnt_d = '0;
        end else if (sclk_fall) begin
          rx_sh_d  = {rx_sh_q[5:0], mosi_s};
          bitcnt_d = bitcnt_q + 3'd1;
          if (bitcnt_q == 3'd7) begin
            rx_data_d = {rx_sh_q, mosi_s};
            rx_done   = 1'b1;
          end
        end else if (sclk_rise) begin
          if (bitcnt_q == 3'd0) load = 1'b1;
          else                  tx_sh_d = {tx_sh_q[6:0], 1'b1};
        end
      end
      default: state_d = ST_LOCKOUT;
    endcase

    // A load in the same cycle as an accept sees the register empty, so it takes FILL_BYTE.
    if (load) begin
      tx_sh_d     = hold_full_q ? hold_q : FILL_BYTE;
      udr_set     = ~hold_full_q;
      hold_full_d = 1'b0;
    end
    if (accept) begin
      hold_d      = tx_data_i;
      hold_full_d = 1'b1;
    end

    if (rx_done) begin
      rx_valid_d = 1'b1;
      ovr_set    = rx_valid_q & ~rx_ack_i;
    end else if (rx_ack_i) begin
      rx_valid_d = 1'b0;
    end

    ovr_d  = (ovr_q  & ~clr_flags_i) | ovr_set;
    udr_d  = (udr_q  & ~clr_flags_i) | udr_set;
    ferr_d = (ferr_q & ~clr_flags_i) | ferr_set;
  end

  assign miso_oe_o   = (state_q == ST_ACTIVE);
  assign miso_o      = (state_q == ST_ACTIVE) ? tx_sh_q[7] : 1'b1;
  assign tx_ready_o  = ~hold_full_q;
  assign rx_data_o   = rx_data_q;
  assign rx_valid_o  = rx_valid_q;
  assign overrun_o   = ovr_q;
  assign underrun_o  = udr_q;
  assign frame_err_o = ferr_q;

endmodule

`default_nettype wire
